// File: rtl/imem_loader_if.sv
// imem_loader_if
// Byte stream (valid/ready) into the loader plus the instruction RAM write
// port coming out of it.
//   s_valid, s_data, s_ready : byte stream, transfer when s_valid && s_ready
//   mem_we, mem_addr, mem_wdata : one-cycle word write strobe, address, data
// Modports: slave = loader side, master = stream source / RAM side.
interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time writer for the instruction RAM. Accepts a stream of
// LEN_LO, LEN_HI, N*4 little-endian data bytes and one checksum byte, writes
// each assembled word to consecutive addresses from 0, and releases the CPU
// from reset only after a load whose checksum matches.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a load (honoured in IDLE, DONE, ERR)
//   bus             : stream input and RAM write port (imem_loader_if.slave)
//   cpu_rst_n       : CPU reset, high only in DONE
//   busy/done/err   : load in progress / last load good / last load bad
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | after reset, waiting for start
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte, range check
// DATA  | collecting data bytes, one RAM write per 4 bytes
// CSUM  | waiting for checksum byte
// DONE  | load good, CPU released
// ERR   | bad length or checksum, CPU held in reset
module imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           cpu_rst_n,
    output logic           busy,
    output logic           done,
    output logic           err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t            state_q, state_nxt;
    logic [15:0]       len_q, len_nxt;
    logic [ADDR_W-1:0] word_idx_q, word_idx_nxt;
    logic [1:0]        byte_idx_q, byte_idx_nxt;
    logic [7:0]        sum_q, sum_nxt;
    logic [23:0]       buf_q, buf_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic              s_ready_q, we_q, cpu_rst_n_q, busy_q, done_q, err_q;
    logic              accept;
    logic [15:0]       len_full;

    assign accept   = bus.s_valid && s_ready_q;
    assign len_full = {bus.s_data, len_q[7:0]};

    always_comb begin
        state_nxt    = state_q;
        len_nxt      = len_q;
        word_idx_nxt = word_idx_q;
        byte_idx_nxt = byte_idx_q;
        sum_nxt      = sum_q;
        buf_nxt      = buf_q;
        we_nxt       = 1'b0;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt    = S_LEN0;
                    word_idx_nxt = '0;
                    byte_idx_nxt = '0;
                    sum_nxt      = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_nxt   = {8'h00, bus.s_data};
                    state_nxt = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_nxt = len_full;
                    if (32'(len_full) > DEPTH_U)
                        state_nxt = S_ERR;
                    else if (len_full == 16'd0)
                        state_nxt = S_CSUM;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_nxt      = sum_q + bus.s_data;
                    byte_idx_nxt = byte_idx_q + 2'd1;
                    // Bytes shift in from the top so that after three bytes
                    // buf_q holds {b2,b1,b0} ready for the completing byte.
                    buf_nxt      = {bus.s_data, buf_q[23:8]};
                    if (byte_idx_q == 2'd3) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = word_idx_q;
                        wdata_nxt = {bus.s_data, buf_q};
                        if (32'(word_idx_q) == 32'(len_q) - 32'd1)
                            state_nxt = S_CSUM;
                        else
                            word_idx_nxt = word_idx_q + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_nxt = (bus.s_data == sum_q) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change in
    // the same cycle the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            sum_q       <= '0;
            buf_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            s_ready_q   <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            len_q       <= len_nxt;
            word_idx_q  <= word_idx_nxt;
            byte_idx_q  <= byte_idx_nxt;
            sum_q       <= sum_nxt;
            buf_q       <= buf_nxt;
            we_q        <= we_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            s_ready_q   <= (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                           (state_nxt == S_DATA) || (state_nxt == S_CSUM);
            busy_q      <= (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                           (state_nxt == S_DATA) || (state_nxt == S_CSUM);
            cpu_rst_n_q <= (state_nxt == S_DONE);
            done_q      <= (state_nxt == S_DONE);
            err_q       <= (state_nxt == S_ERR);
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rst_n     = cpu_rst_n_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader: good/bad checksum loads, length error,
// empty load, stream gaps, ignored start, mid-load reset and restart.
module tb_imem_loader;
    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rst_n, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader_if #(.ADDR_W(12)) bus ();

    imem_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wq_addr.push_back(bus.mem_addr);
            wq_data.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int cnt;
        if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        cnt = 0;
        while (bus.s_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check("s_ready_timeout", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t bytes, input bit gaps);
        foreach (bytes[i]) send_byte(bytes[i], gaps);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            check({tag, "_a0"}, {20'd0, wq_addr[0]}, 32'd0);
            check({tag, "_d0"}, wq_data[0], 32'h00100013);
            check({tag, "_a1"}, {20'd0, wq_addr[1]}, 32'd1);
            check({tag, "_d1"}, wq_data[1], 32'h00200093);
        end
    endtask

    task automatic check_status(input string tag, input logic [4:0] exp);
        // exp = {s_ready, busy, done, err, cpu_rst_n}
        check(tag, {27'd0, bus.s_ready, busy, done, err, cpu_rst_n}, {27'd0, exp});
    endtask

    initial begin
        byte_q_t good, bad, lenerr, empty, part_a, part_b, six;
        good   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hD6};
        bad    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hD7};
        lenerr = '{8'h01, 8'h10};
        empty  = '{8'h00, 8'h00, 8'h00};
        part_a = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10};
        part_b = '{8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hD6};
        six    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_status("reset_status", 5'b00000);
        check("reset_we", {31'd0, bus.mem_we}, 32'd0);
        check("reset_addr", {20'd0, bus.mem_addr}, 32'd0);
        check("reset_wdata", bus.mem_wdata, 32'd0);

        // good 2-word load
        pulse_start();
        check_status("start_ready", 5'b11000);
        send_stream(good, 1'b0);
        check_status("good_done", 5'b00101);
        check_two_writes("good");

        // bad checksum
        wq_addr.delete(); wq_data.delete();
        pulse_start();
        check_status("done_start", 5'b11000);
        send_stream(bad, 1'b0);
        check_status("bad_err", 5'b00010);
        check_two_writes("bad");

        // length too large
        wq_addr.delete(); wq_data.delete();
        pulse_start();
        send_stream(lenerr, 1'b0);
        check_status("len_err", 5'b00010);
        repeat (3) @(negedge clk);
        check("len_nwr", wq_addr.size(), 32'd0);

        // empty load
        pulse_start();
        send_stream(empty, 1'b0);
        check_status("empty_done", 5'b00101);
        check("empty_nwr", wq_addr.size(), 32'd0);

        // random gaps
        pulse_start();
        send_stream(good, 1'b1);
        check_status("gap_done", 5'b00101);
        check_two_writes("gap");

        // start during DATA is ignored
        wq_addr.delete(); wq_data.delete();
        pulse_start();
        send_stream(part_a, 1'b0);
        pulse_start();
        check_status("mid_start", 5'b11000);
        send_stream(part_b, 1'b0);
        check_status("mid_done", 5'b00101);
        check_two_writes("mid");

        // reset after 6 data bytes
        wq_addr.delete(); wq_data.delete();
        pulse_start();
        send_stream(six, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_status("rst_status", 5'b00000);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", {20'd0, bus.mem_addr}, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_nwr", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) check("rst_d0", wq_data[0], 32'h00100013);

        // restart full load
        wq_addr.delete(); wq_data.delete();
        pulse_start();
        send_stream(good, 1'b0);
        check_status("re_done", 5'b00101);
        check_two_writes("re");

        // start in DONE drops cpu_rst_n next cycle
        pulse_start();
        check_status("done_restart", 5'b11000);

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check_status("rst_start", 5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
